// File: rtl/receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM states and frame format constants.
package receiver_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SIZE,
        DATA,
        CRC,
        STOP,
        WAITLOW
    } state_e;

    localparam logic [7:0] CRC_POLY  = 8'h07;
    localparam logic       START_BIT = 1'b1;
    localparam logic       STOP_BIT  = 1'b0;
    localparam int         MAX_BYTES = 16;
    localparam int         SIZE_BITS = 4;

endpackage

// File: rtl/receiver_crc.sv
// Serial MSB-first CRC-8 engine; one message bit is absorbed per enabled clock.
module receiver_crc
    import receiver_pkg::*;
(
    input  logic       en,
    input  logic       clk,
    input  logic       reset,
    input  logic       crcin,
    output logic [7:0] crcout
);

    logic [7:0] crc_q;
    logic       fb;

    assign fb     = crc_q[7] ^ crcin;
    assign crcout = crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= 8'h00;
        end else if (en) begin
            crc_q <= {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/receiver.sv
// Serial frame receiver: start bit, 4-bit byte count, payload, CRC-8 and stop bit,
// sampled mid-bit with a per-frame latched baud divisor.
module receiver
    import receiver_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RX,
    input  logic [7:0]               baudrate,
    output logic                     RXI,
    output logic                     rf,
    output logic [SIZE_BITS-1:0]     framesize,
    output logic [MAX_BYTES*8-1:0]   framebits,
    output logic                     crcerr,
    output logic                     frameerr
);

    state_e                   state_q;
    logic                     sync1_q, sync2_q, rxPrev_q;
    logic [1:0]               syncFill_q;
    logic                     armed_q;
    logic [7:0]               baud_q;
    logic [7:0]               cnt_q;
    logic [6:0]               bitCnt_q;
    logic [SIZE_BITS-1:0]     size_q;
    logic [MAX_BYTES*8-1:0]   payload_q;
    logic [7:0]               rxCrc_q;
    logic                     stopBit_q;
    logic                     pend_q;
    logic                     crcClr_q;
    logic                     rxi_q, rf_q, crcerr_q, frameerr_q;
    logic [SIZE_BITS-1:0]     framesize_q;
    logic [MAX_BYTES*8-1:0]   framebits_q;

    logic                     rxBit, riseEdge, expire, crcEn, crcRst;
    logic [7:0]               baud_d;
    logic [SIZE_BITS-1:0]     size_d;
    logic [6:0]               dataLast;
    logic [7:0]               crcOut;

    assign rxBit    = sync2_q;
    assign riseEdge = armed_q & sync2_q & ~rxPrev_q;
    assign expire   = (cnt_q <= 8'd1);
    assign baud_d   = (baudrate < 8'd2) ? 8'd2 : baudrate;
    assign size_d   = {size_q[SIZE_BITS-2:0], rxBit};
    assign dataLast = {size_q, 3'b000} - 7'd1;
    assign crcEn    = expire && ((state_q == SIZE) || (state_q == DATA));
    // The engine is held cleared whenever the receiver is idle, so each frame starts from zero.
    assign crcRst   = reset | crcClr_q;

    assign RXI       = rxi_q;
    assign rf        = rf_q;
    assign framesize = framesize_q;
    assign framebits = framebits_q;
    assign crcerr    = crcerr_q;
    assign frameerr  = frameerr_q;

    receiver_crc u_crc (
        .en     (crcEn),
        .clk    (clk),
        .reset  (crcRst),
        .crcin  (rxBit),
        .crcout (crcOut)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            rxPrev_q    <= 1'b0;
            syncFill_q  <= 2'b00;
            armed_q     <= 1'b0;
            baud_q      <= 8'd0;
            cnt_q       <= 8'd0;
            bitCnt_q    <= 7'd0;
            size_q      <= '0;
            payload_q   <= '0;
            rxCrc_q     <= 8'h00;
            stopBit_q   <= 1'b0;
            pend_q      <= 1'b0;
            crcClr_q    <= 1'b1;
            rxi_q       <= 1'b1;
            rf_q        <= 1'b0;
            crcerr_q    <= 1'b0;
            frameerr_q  <= 1'b0;
            framesize_q <= '0;
            framebits_q <= '0;
        end else begin
            sync1_q    <= RX;
            sync2_q    <= sync1_q;
            rxPrev_q   <= sync2_q;
            syncFill_q <= {syncFill_q[0], 1'b1};
            // A start edge only counts once the synchronizer has shown a real low line after reset.
            if (syncFill_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
            rf_q     <= 1'b0;
            crcClr_q <= (state_q == IDLE) || (state_q == WAITLOW);
            if (!expire) begin
                cnt_q <= cnt_q - 8'd1;
            end

            case (state_q)
                IDLE: begin
                    if (riseEdge) begin
                        baud_q    <= baud_d;
                        cnt_q     <= baud_d >> 1;
                        bitCnt_q  <= 7'd0;
                        size_q    <= '0;
                        payload_q <= '0;
                        pend_q    <= 1'b0;
                        rxi_q     <= 1'b0;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (expire) begin
                        if (rxBit == START_BIT) begin
                            cnt_q   <= baud_q;
                            state_q <= SIZE;
                        end else begin
                            rxi_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                SIZE: begin
                    if (expire) begin
                        cnt_q  <= baud_q;
                        size_q <= size_d;
                        if (bitCnt_q == 7'd3) begin
                            bitCnt_q <= 7'd0;
                            state_q  <= (size_d == '0) ? CRC : DATA;
                        end else begin
                            bitCnt_q <= bitCnt_q + 7'd1;
                        end
                    end
                end
                DATA: begin
                    if (expire) begin
                        cnt_q <= baud_q;
                        // Byte k lands at [8k+7:8k], its first (MSB) bit at the top of the byte.
                        payload_q[{bitCnt_q[6:3], ~bitCnt_q[2:0]}] <= rxBit;
                        if (bitCnt_q == dataLast) begin
                            bitCnt_q <= 7'd0;
                            state_q  <= CRC;
                        end else begin
                            bitCnt_q <= bitCnt_q + 7'd1;
                        end
                    end
                end
                CRC: begin
                    if (expire) begin
                        cnt_q   <= baud_q;
                        rxCrc_q <= {rxCrc_q[6:0], rxBit};
                        if (bitCnt_q == 7'd7) begin
                            bitCnt_q <= 7'd0;
                            state_q  <= STOP;
                        end else begin
                            bitCnt_q <= bitCnt_q + 7'd1;
                        end
                    end
                end
                STOP: begin
                    if (pend_q) begin
                        pend_q      <= 1'b0;
                        rf_q        <= 1'b1;
                        framesize_q <= size_q;
                        framebits_q <= payload_q;
                        crcerr_q    <= (rxCrc_q != crcOut);
                        frameerr_q  <= (stopBit_q != STOP_BIT);
                        rxi_q       <= 1'b1;
                        cnt_q       <= 8'd0;
                        state_q     <= (stopBit_q == STOP_BIT) ? IDLE : WAITLOW;
                    end else if (expire) begin
                        stopBit_q <= rxBit;
                        pend_q    <= 1'b1;
                    end
                end
                WAITLOW: begin
                    if (!rxBit) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    rxi_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the frame receiver: directed scenarios plus random frames,
// expected frames queued at stimulus time and checked by a monitor on every rf pulse.
`timescale 1ns/1ps
module tb_receiver;

    logic         clk = 1'b0;
    logic         reset;
    logic         RX;
    logic [7:0]   baudrate;
    logic         RXI, rf, crcerr, frameerr;
    logic [3:0]   framesize;
    logic [127:0] framebits;

    always #5 clk = ~clk;

    receiver dut (
        .clk       (clk),
        .reset     (reset),
        .RX        (RX),
        .baudrate  (baudrate),
        .RXI       (RXI),
        .rf        (rf),
        .framesize (framesize),
        .framebits (framebits),
        .crcerr    (crcerr),
        .frameerr  (frameerr)
    );

    typedef struct {
        logic [3:0]   size;
        logic [127:0] bits;
        logic         crcErr;
        logic         frameErr;
    } expFrame_t;

    expFrame_t expQ[$];
    expFrame_t held;
    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Remainder of (message * x^8) divided by x^8+x^2+x+1, by plain long division.
    function automatic logic [7:0] refCrc(input logic [3:0] size, input logic [7:0] data [16]);
        logic msg[$];
        int   rem;
        rem = 0;
        for (int i = 3; i >= 0; i--) msg.push_back(size[i]);
        for (int k = 0; k < int'(size); k++)
            for (int i = 7; i >= 0; i--) msg.push_back(data[k][i]);
        repeat (8) msg.push_back(1'b0);
        foreach (msg[n]) begin
            rem = (rem << 1) | int'(msg[n]);
            if ((rem & 32'h100) != 0) rem = rem ^ 32'h107;
        end
        return rem[7:0];
    endfunction

    task automatic checkHeld(input string tag);
        checkOutput({tag, " framesize"}, 128'(framesize), 128'(held.size));
        checkOutput({tag, " framebits"}, framebits, held.bits);
        checkOutput({tag, " crcerr"}, 128'(crcerr), 128'(held.crcErr));
        checkOutput({tag, " frameerr"}, 128'(frameerr), 128'(held.frameErr));
    endtask

    // Sends one frame bit-serially; abortAt >= 0 stops after that many bits and queues nothing.
    task automatic applyStimulus(input int baud, input logic [3:0] size, input logic [7:0] data [16],
                                 input logic [7:0] crcVal, input logic stopVal, input int abortAt);
        int        b;
        logic      q[$];
        expFrame_t e;
        b = (baud < 2) ? 2 : baud;
        q.push_back(1'b1);
        for (int i = 3; i >= 0; i--) q.push_back(size[i]);
        for (int k = 0; k < int'(size); k++)
            for (int i = 7; i >= 0; i--) q.push_back(data[k][i]);
        for (int i = 7; i >= 0; i--) q.push_back(crcVal[i]);
        q.push_back(stopVal);
        if (abortAt < 0) begin
            e.size = size;
            e.bits = '0;
            for (int k = 0; k < int'(size); k++) e.bits[8*k +: 8] = data[k];
            e.crcErr   = (crcVal != refCrc(size, data));
            e.frameErr = stopVal;
            expQ.push_back(e);
        end
        @(negedge clk);
        baudrate = 8'(baud);
        for (int n = 0; n < q.size(); n++) begin
            if (abortAt >= 0 && n == abortAt) return;
            RX = q[n];
            if (n == 5) baudrate = 8'($urandom_range(0, 255));
            if (n == 6) begin
                checkOutput("RXI busy", 128'(RXI), 128'(0));
                checkHeld("hold mid-frame");
            end
            repeat (b) @(negedge clk);
        end
        if (stopVal) begin
            repeat (3 * b) @(negedge clk);
            checkOutput("RXI waitlow", 128'(RXI), 128'(1));
            RX = 1'b0;
        end
        repeat (2 * b + 6) @(negedge clk);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL rf timeout: got %0d frames pending, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        expFrame_t e;
        if (rf === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected rf: got pulse, expected none");
            end else begin
                e = expQ.pop_front();
                checkOutput("rf framesize", 128'(framesize), 128'(e.size));
                checkOutput("rf framebits", framebits, e.bits);
                checkOutput("rf crcerr", 128'(crcerr), 128'(e.crcErr));
                checkOutput("rf frameerr", 128'(frameerr), 128'(e.frameErr));
                checkOutput("rf RXI", 128'(RXI), 128'(1));
                held = e;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] data [16];
        logic [7:0] good, crcVal;
        logic [3:0] sz;
        logic       stopVal;
        int         baud;

        held     = '{size: 4'd0, bits: '0, crcErr: 1'b0, frameErr: 1'b0};
        reset    = 1'b1;
        RX       = 1'b0;
        baudrate = 8'd4;
        foreach (data[k]) data[k] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset RXI", 128'(RXI), 128'(1));
        checkOutput("reset rf", 128'(rf), 128'(0));
        checkHeld("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] scenario 1: empty frame");
        applyStimulus(4, 4'd0, data, 8'h00, 1'b0, -1);
        waitDrain();

        $display("[TB] scenario 2/3: one zero byte, good and bad CRC");
        applyStimulus(8, 4'd1, data, 8'h15, 1'b0, -1);
        waitDrain();
        applyStimulus(8, 4'd1, data, 8'h14, 1'b0, -1);
        waitDrain();

        $display("[TB] scenario 4: glitch in idle");
        baudrate = 8'd8;
        RX = 1'b1;
        repeat (2) @(negedge clk);
        RX = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("glitch RXI start", 128'(RXI), 128'(0));
        repeat (20) @(negedge clk);
        checkOutput("glitch RXI idle", 128'(RXI), 128'(1));
        checkHeld("glitch");

        $display("[TB] scenario 5: stop bit error then recovery");
        data[0] = 8'hA5;
        data[1] = 8'h3C;
        applyStimulus(5, 4'd2, data, refCrc(4'd2, data), 1'b1, -1);
        waitDrain();
        applyStimulus(5, 4'd2, data, refCrc(4'd2, data), 1'b0, -1);
        waitDrain();

        $display("[TB] scenario 6: reset during payload");
        foreach (data[k]) data[k] = 8'($urandom);
        applyStimulus(6, 4'd15, data, refCrc(4'd15, data), 1'b0, 40);
        reset = 1'b1;
        RX    = 1'b0;
        repeat (3) @(negedge clk);
        held = '{size: 4'd0, bits: '0, crcErr: 1'b0, frameErr: 1'b0};
        checkOutput("mid reset RXI", 128'(RXI), 128'(1));
        checkHeld("mid reset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkHeld("after reset");
        data[0] = 8'h81;
        data[1] = 8'h7E;
        data[2] = 8'hFF;
        applyStimulus(3, 4'd3, data, refCrc(4'd3, data), 1'b0, -1);
        waitDrain();

        $display("[TB] random frames");
        for (int f = 0; f < 15; f++) begin
            baud = $urandom_range(0, 8);
            sz   = 4'($urandom_range(0, 15));
            foreach (data[k]) data[k] = 8'($urandom);
            good    = refCrc(sz, data);
            crcVal  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : good;
            stopVal = ($urandom_range(0, 5) == 0);
            applyStimulus(baud, sz, data, crcVal, stopVal, -1);
            waitDrain();
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 clk  input  1  — single system clock; all state updates on its rising edge.
REQ-002 reset  input  1  — asynchronous, active-high reset.
REQ-003 RX  input  1  — serial line; idle low.
REQ-004 baudrate  input  8  — clocks per bit; latched at start-bit detection; values 0 and 1 are clamped to 2.
REQ-005 RXI  output  1  — idle indicator; 1 = idle, 0 = frame in progress.
REQ-006 rf  output  1  — frame-received strobe; one-cycle pulse.
REQ-007 framesize  output  4  — received byte count; valid from the rf pulse until the next rf pulse.
REQ-008 framebits  output  128  — received payload; byte k occupies [8k+7:8k].
REQ-009 crcerr  output  1  — CRC mismatch flag; valid with rf.
REQ-010 frameerr  output  1  — stop-bit error flag; valid with rf.

Function
REQ-011 Frame format SHALL be: start bit (1); framesize, 4 bits, MSB first; framesize bytes, each MSB first, byte 0 first; CRC, 8 bits, MSB first; stop bit (0).
REQ-012 RX SHALL pass through a 2-flop synchronizer before any use.
REQ-013 States SHALL be IDLE, START, SIZE, DATA, CRC, STOP, WAITLOW.
REQ-014 IDLE: a synchronized 0->1 transition SHALL latch baudrate, load the bit counter with baudrate/2 (floor), clear the CRC, and enter START.
REQ-015 START: on counter expiry, if RX=1 the block SHALL enter SIZE with the counter loaded to baudrate; otherwise it SHALL return to IDLE without pulsing rf (false start).
REQ-016 Sampling: in SIZE, DATA, CRC and STOP, RX SHALL be sampled once per counter expiry (mid-bit), and the counter SHALL then reload to the latched baudrate.
REQ-017 SIZE: after 4 samples the block SHALL enter DATA, or CRC directly if the received framesize is 0.
REQ-018 DATA: after framesize×8 samples the block SHALL enter CRC.
REQ-019 SIZE and DATA samples SHALL be fed to the CRC engine.
REQ-020 DATA samples SHALL be shifted into the payload register.
REQ-021 CRC engine: CRC-8, polynomial 0x07, init 0x00, serial MSB-first update: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0).
REQ-022 CRC: the 8 samples SHALL be collected and compared with the engine value; the engine SHALL be frozen during this state.
REQ-023 STOP: one sample SHALL be taken. On the next cycle the block SHALL pulse rf and update framesize, framebits, crcerr (mismatch) and frameerr (sample=1).
REQ-024 After STOP the block SHALL go to IDLE if the stop sample was 0, and to WAITLOW otherwise; WAITLOW SHALL hold until RX=0, then go to IDLE.
REQ-025 Payload bytes at index ≥ framesize SHALL read 0 in framebits.
REQ-026 framesize, framebits, crcerr and frameerr SHALL hold between rf pulses, including while a frame is being received or after a false start.
REQ-027 RXI SHALL be 0 in START through STOP and 1 in IDLE and WAITLOW.
REQ-028 A change on the baudrate input mid-frame SHALL have no effect until the next start bit.

Reset
REQ-029 Reset SHALL force: state IDLE, RXI=1, rf=0, crcerr=0, frameerr=0, framesize=0, framebits=0, CRC=0x00, counters=0, synchronizer=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no rf pulse; reception SHALL resume only on a fresh 0->1 edge after deassertion.

Structure
REQ-031 A shared package SHALL hold: the state enum, CRC_POLY=8'h07, START_BIT=1, STOP_BIT=0, MAX_BYTES=16, SIZE_BITS=4.
REQ-032 The CRC engine SHALL be the team's existing serial crc module (ports en, clk, reset, crcin, crcout), instantiated once as the only sub-module.

Verification
REQ-033 Scenario 1: baudrate=4; frame with size 0x0 and CRC 0x00 -> one rf pulse, framesize=0, framebits=0, crcerr=0, frameerr=0.
REQ-034 Scenario 2: baudrate=8; size 0x1, byte 0x00, CRC 0x15 -> rf, framesize=1, framebits[7:0]=0x00, crcerr=0.
REQ-035 Scenario 3: same frame with CRC 0x14 -> rf, crcerr=1, payload still captured.
REQ-036 Scenario 4: baudrate=8; 2-cycle RX high glitch in IDLE -> no rf pulse, RXI returns to 1, outputs unchanged.
REQ-037 Scenario 5: valid frame with stop bit driven 1 -> rf, frameerr=1; the block stays in WAITLOW until RX=0, then accepts the next frame.
REQ-038 Scenario 6: reset pulse during DATA of a size-15 frame -> no rf pulse, all outputs at reset values; a subsequent valid frame with baudrate=3 is received correctly.
